serial_sub: RTL

- Bit-serial, LSB-first two's-complement subtractor. Computes D = A - B - BIN over WIDTH clock cycles.
- Each cycle it evaluates one full-subtractor bit (difference and borrow) and holds the borrow in a register.
- This is the subtract-direction counterpart of the combinational full-adder cell. It serves as an area-minimal arithmetic unit for the small datapaths synthesized onto the standard-cell library.
- It is controlled by a START/BUSY/DONE handshake.

---
 rtl/serial_sub_if.sv | 27 ++
 rtl/serial_sub.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             ZERO;
  logic             DS;

  // Requester side: drives operands and START, observes status and result.
  modport master (
    output START, A, B, BIN,
    input  BUSY, DONE, D, BOUT, ZERO, DS
  );

  // Subtractor side.
  modport slave (
    input  START, A, B, BIN,
    output BUSY, DONE, D, BOUT, ZERO, DS
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: D = A - B - BIN over WIDTH cycles, one
// full-subtractor bit per cycle with the borrow held in a flop.
module serial_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input logic         CLK,
  input logic         RN,
  serial_sub_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]       state_q,  state_nxt;
  logic [WIDTH-1:0] op_a_q,   op_a_nxt;
  logic [WIDTH-1:0] op_b_q,   op_b_nxt;
  logic             borrow_q, borrow_nxt;
  logic [CW-1:0]    cnt_q,    cnt_nxt;
  logic [WIDTH-1:0] d_q,      d_nxt;
  logic             bout_q,   bout_nxt;
  logic             zero_q,   zero_nxt;
  logic             busy_q,   busy_nxt;
  logic             done_q,   done_nxt;

  logic             bit_a, bit_b, bit_c;
  logic             diff_c;
  logic             borrow_new;
  logic [WIDTH-1:0] d_shift;

  // Full-subtractor cell on the current LSBs and held borrow.
  always_comb begin
    bit_a      = op_a_q[0];
    bit_b      = op_b_q[0];
    bit_c      = borrow_q;
    diff_c     = bit_a ^ bit_b ^ bit_c;
    borrow_new = (~bit_a & bit_b) | (~bit_a & bit_c) | (bit_b & bit_c);
    d_shift    = {diff_c, d_q[WIDTH-1:1]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state_q;
    op_a_nxt   = op_a_q;
    op_b_nxt   = op_b_q;
    borrow_nxt = borrow_q;
    cnt_nxt    = cnt_q;
    d_nxt      = d_q;
    bout_nxt   = bout_q;
    zero_nxt   = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          op_a_nxt   = bus.A;
          op_b_nxt   = bus.B;
          borrow_nxt = bus.BIN;
          cnt_nxt    = '0;
          d_nxt      = '0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        d_nxt      = d_shift;
        op_a_nxt   = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_nxt   = {1'b0, op_b_q[WIDTH-1:1]};
        borrow_nxt = borrow_new;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: return the counter to zero rather than wrapping.
          cnt_nxt   = '0;
          bout_nxt  = borrow_new;
          zero_nxt  = (d_shift == '0);
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      op_a_q   <= op_a_nxt;
      op_b_q   <= op_b_nxt;
      borrow_q <= borrow_nxt;
      cnt_q    <= cnt_nxt;
      d_q      <= d_nxt;
      bout_q   <= bout_nxt;
      zero_q   <= zero_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Output drive; DS is the live difference bit, gated to SHIFT.
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.D    = d_q;
  assign bus.BOUT = bout_q;
  assign bus.ZERO = zero_q;
  assign bus.DS   = (state_q == SHIFT) ? diff_c : 1'b0;

endmodule
